// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: control pipeline and hazard unit for the pipelined MIPS core.
// Carries each decoded control bundle from D through NSTG later stages. It compares
// the source Tuse against the destination Tnew in each stage to raise stalls, and it
// selects D-stage forwarding sources. It inserts bubbles and applies exception flush.
// A mul/div busy counter holds HI/LO users in D until the running op completes.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   d_valid                 D holds a real instruction (0 = treat D as a bubble)
//   d_ctrl                  decoded control bundle of the D instruction
//   d_a1/d_a2               source register addresses (0 = unused)
//   d_tuse1/d_tuse2         cycles until each source is consumed (0 = used in D)
//   d_a3, d_tnew            destination register and cycles after E until the result exists
//   d_md_start, d_md_div    starts a mul/div; 1 = DIV latency, 0 = MUL latency
//   d_md_use                reads or writes HI/LO, or starts a mul/div
//   flush                   exception flush of every stage younger than W
//   stg_ctrl, stg_a3        per-stage bundle and destination; stage k sits at slice k-1
//   fwd1_sel/fwd2_sel       D source select: 0 = register file, k = stage k
//   stall, pc_en, d_en      hazard stall; pc_en = d_en = ~stall
//   md_busy                 mul/div counter non-zero
module pipe_hazard_ctrl #(
    parameter int unsigned CTRL_W  = 24,
    parameter int unsigned NSTG    = 3,
    parameter int unsigned TW      = 2,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     d_valid,
    input  logic [CTRL_W-1:0]        d_ctrl,
    input  logic [4:0]               d_a1,
    input  logic [4:0]               d_a2,
    input  logic [TW-1:0]            d_tuse1,
    input  logic [TW-1:0]            d_tuse2,
    input  logic [4:0]               d_a3,
    input  logic [TW-1:0]            d_tnew,
    input  logic                     d_md_start,
    input  logic                     d_md_div,
    input  logic                     d_md_use,
    input  logic                     flush,
    output logic [NSTG*CTRL_W-1:0]   stg_ctrl,
    output logic [NSTG*5-1:0]        stg_a3,
    output logic [2:0]               fwd1_sel,
    output logic [2:0]               fwd2_sel,
    output logic                     stall,
    output logic                     pc_en,
    output logic                     d_en,
    output logic                     md_busy
);

    localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    // Stage state; array index i holds stage i+1 (index 0 is E)
    logic [CTRL_W-1:0] s_ctrl [NSTG];
    logic [4:0]        s_a3   [NSTG];
    logic [TW-1:0]     s_tnew [NSTG];

    // Only stage 1 needs the mul/div start flags: the counter loads from there
    logic              s1_md_start;
    logic              s1_md_div;
    logic [CNT_W-1:0]  md_cnt;

    logic              hz1;
    logic              hz2;
    logic              md_stall;
    logic              load_d;

    // Hazard search; walking from the farthest stage to the nearest lets the nearest match win
    always_comb begin
        hz1      = 1'b0;
        hz2      = 1'b0;
        fwd1_sel = 3'd0;
        fwd2_sel = 3'd0;
        for (int i = int'(NSTG) - 1; i >= 0; i--) begin
            if ((d_a1 != 5'd0) && (s_a3[i] == d_a1)) begin
                hz1      = (s_tnew[i] > d_tuse1);
                fwd1_sel = (s_tnew[i] == '0) ? 3'(i + 1) : 3'd0;
            end
            if ((d_a2 != 5'd0) && (s_a3[i] == d_a2)) begin
                hz2      = (s_tnew[i] > d_tuse2);
                fwd2_sel = (s_tnew[i] == '0) ? 3'(i + 1) : 3'd0;
            end
        end
    end

    // A mul/div in E has not loaded the counter yet, so it also blocks HI/LO users
    assign md_busy  = (md_cnt != '0);
    assign md_stall = d_valid & d_md_use & (md_busy | s1_md_start);
    assign stall    = d_valid & (hz1 | hz2 | md_stall);
    assign pc_en    = ~stall;
    assign d_en     = ~stall;
    assign load_d   = d_valid & ~stall;

    // Stage pipeline: flush bubbles everything, else stage 1 takes D or a bubble and the rest advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NSTG); i++) begin
                s_ctrl[i] <= '0;
                s_a3[i]   <= '0;
                s_tnew[i] <= '0;
            end
            s1_md_start <= 1'b0;
            s1_md_div   <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < int'(NSTG); i++) begin
                s_ctrl[i] <= '0;
                s_a3[i]   <= '0;
                s_tnew[i] <= '0;
            end
            s1_md_start <= 1'b0;
            s1_md_div   <= 1'b0;
        end else begin
            if (load_d) begin
                s_ctrl[0]   <= d_ctrl;
                s_a3[0]     <= d_a3;
                s_tnew[0]   <= d_tnew;
                s1_md_start <= d_md_start;
                s1_md_div   <= d_md_div;
            end else begin
                s_ctrl[0]   <= '0;
                s_a3[0]     <= '0;
                s_tnew[0]   <= '0;
                s1_md_start <= 1'b0;
                s1_md_div   <= 1'b0;
            end
            for (int i = 1; i < int'(NSTG); i++) begin
                s_ctrl[i] <= s_ctrl[i-1];
                s_a3[i]   <= s_a3[i-1];
                s_tnew[i] <= (s_tnew[i-1] != '0) ? (s_tnew[i-1] - TW'(1)) : '0;
            end
        end
    end

    // Mul/div busy counter; flush leaves it alone so an issued op still completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (s1_md_start) begin
            md_cnt <= s1_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    // Pack stage k into slice [k*CTRL_W-1 -: CTRL_W]
    for (genvar k = 0; k < int'(NSTG); k++) begin : g_out
        assign stg_ctrl[k*CTRL_W +: CTRL_W] = s_ctrl[k];
        assign stg_a3[k*5 +: 5]             = s_a3[k];
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. The driver issues D-stage vectors and queues the
// hand-computed response. The monitor drains the queue at each falling edge, or on demand.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CTRL_W = 24;
    localparam int unsigned NSTG   = 3;
    localparam int unsigned TW     = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   d_valid;
    logic [CTRL_W-1:0]      d_ctrl;
    logic [4:0]             d_a1, d_a2, d_a3;
    logic [TW-1:0]          d_tuse1, d_tuse2, d_tnew;
    logic                   d_md_start, d_md_div, d_md_use;
    logic                   flush;
    logic [NSTG*CTRL_W-1:0] stg_ctrl;
    logic [NSTG*5-1:0]      stg_a3;
    logic [2:0]             fwd1_sel, fwd2_sel;
    logic                   stall, pc_en, d_en, md_busy;

    pipe_hazard_ctrl #(
        .CTRL_W(CTRL_W), .NSTG(NSTG), .TW(TW), .MUL_LAT(5), .DIV_LAT(10)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_ctrl(d_ctrl),
        .d_a1(d_a1), .d_a2(d_a2), .d_tuse1(d_tuse1), .d_tuse2(d_tuse2),
        .d_a3(d_a3), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .d_md_use(d_md_use), .flush(flush), .stg_ctrl(stg_ctrl), .stg_a3(stg_a3),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .stall(stall), .pc_en(pc_en),
        .d_en(d_en), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                   stall;
        logic [2:0]             f1;
        logic [2:0]             f2;
        logic                   busy;
        logic                   chk_stg;
        logic [NSTG*CTRL_W-1:0] ctrl;
        logic [NSTG*5-1:0]      a3;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    event  chk_ev;

    // Monitor: compare every queued expectation against the live outputs
    initial begin
        forever begin
            @(negedge clk or chk_ev);
            while (exp_q.size() != 0) begin
                exp_t  e;
                string nm;
                logic  bad;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                bad = (stall !== e.stall) || (pc_en !== !e.stall) || (d_en !== !e.stall) ||
                      (fwd1_sel !== e.f1) || (fwd2_sel !== e.f2) || (md_busy !== e.busy);
                if (e.chk_stg && ((stg_ctrl !== e.ctrl) || (stg_a3 !== e.a3)))
                    bad = 1'b1;
                if (bad) begin
                    errors++;
                    $display("FAIL %s: got stall=%0b pc_en=%0b d_en=%0b f1=%0d f2=%0d busy=%0b ctrl=%h a3=%h | want stall=%0b f1=%0d f2=%0d busy=%0b ctrl=%h a3=%h (stg checked=%0b)",
                             nm, stall, pc_en, d_en, fwd1_sel, fwd2_sel, md_busy, stg_ctrl, stg_a3,
                             e.stall, e.f1, e.f2, e.busy, e.ctrl, e.a3, e.chk_stg);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d required to finish", checks);
        $fatal(1);
    end

    task automatic expect_out(input string nm, input logic st, input logic [2:0] f1,
                              input logic [2:0] f2, input logic busy);
        exp_t e;
        e = '{stall: st, f1: f1, f2: f2, busy: busy, chk_stg: 1'b0, ctrl: '0, a3: '0};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic expect_stg(input string nm, input logic st, input logic [2:0] f1,
                              input logic [2:0] f2, input logic busy,
                              input logic [NSTG*CTRL_W-1:0] c, input logic [NSTG*5-1:0] a);
        exp_t e;
        e = '{stall: st, f1: f1, f2: f2, busy: busy, chk_stg: 1'b1, ctrl: c, a3: a};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic drive(input logic v, input logic [23:0] c,
                         input logic [4:0] a1, input logic [1:0] tu1,
                         input logic [4:0] a2, input logic [1:0] tu2,
                         input logic [4:0] a3, input logic [1:0] tn,
                         input logic ms, input logic md, input logic mu);
        d_valid = v;  d_ctrl = c;
        d_a1 = a1;    d_tuse1 = tu1;
        d_a2 = a2;    d_tuse2 = tu2;
        d_a3 = a3;    d_tnew = tn;
        d_md_start = ms; d_md_div = md; d_md_use = mu;
    endtask

    task automatic idle();
        drive(1'b0, 24'h0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (4) begin
            cyc();
            idle();
        end
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        idle();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        expect_stg("reset_state", 1'b0, 3'd0, 3'd0, 1'b0, '0, '0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        // Load-use: producer tnew=2 against consumer tuse=1 stalls one cycle
        cyc(); drive(1, 24'hA00001, 0, 0, 0, 0, 5, 2, 0, 0, 0);
        expect_stg("lu_issue", 0, 0, 0, 0, '0, '0);
        cyc(); drive(1, 24'hB00002, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_stg("lu_stall", 1, 0, 0, 0, {24'h0, 24'h0, 24'hA00001}, {5'd0, 5'd0, 5'd5});
        cyc();
        expect_stg("lu_bubble", 0, 0, 0, 0, {24'h0, 24'hA00001, 24'h0}, {5'd0, 5'd5, 5'd0});
        cyc(); drive(1, 24'hC00003, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_stg("lu_fwd3", 0, 3'd3, 0, 0, {24'hA00001, 24'h0, 24'hB00002}, {5'd5, 5'd0, 5'd0});
        drain();

        // Branch forwarding, nearest match wins
        cyc(); drive(1, 24'h000011, 0, 0, 0, 0, 8, 0, 0, 0, 0);
        expect_out("bf_issue", 0, 0, 0, 0);
        cyc(); idle();
        expect_out("bf_gap", 0, 0, 0, 0);
        cyc(); drive(1, 24'h000013, 8, 0, 0, 0, 8, 0, 0, 0, 0);
        expect_out("bf_stage2", 0, 3'd2, 0, 0);
        cyc(); drive(1, 24'h000014, 8, 0, 8, 2, 0, 0, 0, 0, 0);
        expect_out("bf_nearest", 0, 3'd1, 3'd1, 0);
        cyc(); drive(1, 24'h000015, 0, 0, 0, 0, 8, 2, 0, 0, 0);
        expect_out("bf_pre", 0, 0, 0, 0);
        cyc(); drive(1, 24'h000016, 8, 2, 0, 0, 0, 0, 0, 0, 0);
        expect_out("bf_near_pending", 0, 0, 0, 0);
        cyc(); drive(1, 24'h000017, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("bf_age_stall", 1, 0, 0, 0);
        cyc();
        expect_out("bf_age_fwd", 0, 3'd3, 0, 0);
        drain();

        // Register 0 never matches; an invalid D never stalls
        cyc(); drive(1, 24'h000021, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        expect_out("z_issue", 0, 0, 0, 0);
        cyc(); drive(1, 24'h000022, 0, 0, 0, 0, 7, 2, 0, 0, 0);
        expect_out("z_reg0", 0, 0, 0, 0);
        cyc(); drive(0, 24'h0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("z_invalid", 0, 0, 0, 0);
        cyc(); drive(1, 24'h000023, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("z_valid_stall", 1, 0, 0, 0);
        cyc();
        expect_out("z_fwd3", 0, 3'd3, 0, 0);
        drain();

        // DIV then MFHI: 1 + 10 stall cycles, busy for the last 10
        cyc(); drive(1, 24'h000031, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        expect_out("div_issue", 0, 0, 0, 0);
        cyc(); drive(1, 24'h000032, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_out("div_e_stall", 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            expect_out($sformatf("div_busy%0d", i), 1, 0, 0, 1);
        end
        cyc();
        expect_out("div_done", 0, 0, 0, 0);
        cyc(); idle();
        expect_out("div_after", 0, 0, 0, 0);
        drain();

        // Flush clears stages; the running MUL counter keeps counting
        cyc(); drive(1, 24'h000041, 0, 0, 0, 0, 3, 1, 1, 0, 1);
        expect_out("mul_issue", 0, 0, 0, 0);
        cyc(); drive(1, 24'h000042, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        expect_out("mul_e", 0, 0, 0, 0);
        cyc(); drive(1, 24'h000043, 0, 0, 0, 0, 6, 0, 1, 0, 1);
        flush = 1'b1;
        expect_stg("pre_flush", 1, 0, 0, 1, {24'h0, 24'h000041, 24'h000042}, {5'd0, 5'd3, 5'd4});
        cyc(); flush = 1'b0; idle();
        expect_stg("post_flush", 0, 0, 0, 1, '0, '0);
        cyc(); expect_out("flush_cnt3", 0, 0, 0, 1);
        cyc(); expect_out("flush_cnt2", 0, 0, 0, 1);
        cyc(); expect_out("flush_cnt1", 0, 0, 0, 1);
        cyc(); expect_out("mul_done", 0, 0, 0, 0);
        cyc(); expect_out("no_reissue", 0, 0, 0, 0);

        // Asynchronous reset mid-DIV with the counter at 6
        cyc(); drive(1, 24'h000051, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        expect_out("div2_issue", 0, 0, 0, 0);
        cyc(); drive(1, 24'h000052, 0, 0, 0, 0, 10, 0, 0, 0, 0);
        expect_out("div2_e", 0, 0, 0, 0);
        cyc(); idle();
        expect_out("div2_c10", 0, 0, 0, 1);
        cyc(); drive(1, 24'h000053, 0, 0, 0, 0, 11, 0, 0, 0, 0);
        cyc(); drive(1, 24'h000054, 0, 0, 0, 0, 12, 0, 0, 0, 0);
        cyc(); drive(1, 24'h000055, 0, 0, 0, 0, 13, 0, 0, 0, 0);
        cyc(); drive(1, 24'h000056, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_stg("pre_reset", 1, 0, 0, 1, {24'h000053, 24'h000054, 24'h000055},
                   {5'd11, 5'd12, 5'd13});
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        expect_stg("async_reset", 0, 0, 0, 0, '0, '0);
        -> chk_ev;
        cyc();
        expect_stg("reset_hold", 0, 0, 0, 0, '0, '0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        cyc();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
